// File: rtl/nibble_serial_adder.sv
// Bit-serial-by-nibble adder: one 4-bit carry-lookahead slice is reused over NIBBLES cycles.
// Reports sum, carry-out and two's-complement overflow with a one-cycle done pulse.
module nibble_serial_adder #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   cin,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   cout,
  output logic                   ovf
);

  localparam int unsigned IDXW = $clog2(NIBBLES);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                      state_q, state_d;
  logic [NIBBLES-1:0][3:0]     a_q, a_d;
  logic [NIBBLES-1:0][3:0]     b_q, b_d;
  logic [NIBBLES-1:0][3:0]     sum_q, sum_d;
  logic [IDXW-1:0]             idx_q, idx_d;
  logic                        carry_q, carry_d;
  logic                        cout_q, cout_d;
  logic                        ovf_q, ovf_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;

  logic [3:0] an, bn, g, p, c, s;
  logic       c4;

  // Carry-lookahead slice over the currently selected nibble.
  always_comb begin
    an   = a_q[idx_q];
    bn   = b_q[idx_q];
    g    = an & bn;
    p    = an ^ bn;
    c[0] = carry_q;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c4   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (&p & c[0]);
    s    = p ^ c;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      RUN: begin
        busy_d       = 1'b1;
        sum_d[idx_q] = s;
        carry_d      = c4;
        idx_d        = idx_q + IDXW'(1);
        if (idx_q == IDXW'(NIBBLES - 1)) begin
          cout_d  = c4;
          ovf_d   = c[3] ^ c4;
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      IDLE, DONE: begin
        // A request in DONE restarts immediately without passing through IDLE.
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          idx_d   = '0;
          state_d = RUN;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (NIBBLES=4): directed table, random ops against
// an arithmetic reference, plus ignored-start, back-to-back and mid-run reset sequences.
module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] a, b;
  logic        cin;
  logic        busy, done, cout, ovf;
  logic [15:0] sum;

  int n_tests = 0;
  int n_fail  = 0;

  nibble_serial_adder #(.NIBBLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Reference: plain integer addition; overflow from carry into the sign bit vs carry out.
  function automatic logic [17:0] model(input logic [15:0] av, input logic [15:0] bv,
                                        input logic ci);
    logic [16:0] full;
    int unsigned lo;
    logic        c15;
    full = 17'(av) + 17'(bv) + 17'(ci);
    lo   = 32'(av[14:0]) + 32'(bv[14:0]) + 32'(ci);
    c15  = lo[15];
    return {c15 ^ full[16], full};
  endfunction

  // Issue one add from a negedge; scramble inputs during RUN; check latency, busy, results, hold.
  task automatic do_add(input logic [15:0] av, input logic [15:0] bv, input logic ci,
                        input logic [15:0] es, input logic eco, input logic eov,
                        input string nm);
    int cyc;
    int busy_cnt;
    start = 1'b1; a = av; b = bv; cin = ci;
    @(negedge clk);
    start = 1'b0; a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
    cyc = 0; busy_cnt = 0;
    while (!done && cyc < 20) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
    check({nm, " latency"}, 32'(cyc), 32'd4);
    check({nm, " busy_cycles"}, 32'(busy_cnt), 32'd4);
    check({nm, " busy_at_done"}, 32'(busy), 32'd0);
    check({nm, " sum"}, 32'(sum), 32'(es));
    check({nm, " cout"}, 32'(cout), 32'(eco));
    check({nm, " ovf"}, 32'(ovf), 32'(eov));
    @(negedge clk);
    check({nm, " done_one_cycle"}, 32'(done), 32'd0);
    check({nm, " sum_hold"}, 32'({sum, cout, ovf}), 32'({es, eco, eov}));
  endtask

  initial begin
    logic [17:0] m;
    logic [15:0] ra, rb;
    logic        rc;
    int          dcnt;
    int          first_done;
    int          second_done;
    logic [15:0] second_sum;

    vecs[0] = '{16'h000B, 16'h0002, 1'b0, 16'h000D, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[4] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[5] = '{16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[6] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[7] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    #2;
    check("reset_outputs", 32'({busy, done, sum, cout, ovf}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++)
      do_add(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].co, vecs[i].ov,
             $sformatf("vec%0d", i));

    for (int i = 0; i < 30; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
      if (i % 5 == 0) rb = 16'h8000 - ra;
      m = model(ra, rb, rc);
      do_add(ra, rb, rc, m[15:0], m[16], m[17], $sformatf("rnd%0d", i));
    end

    // Start during RUN must be ignored.
    start = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; a = 16'hAAAA; b = 16'h5555; cin = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 10 && !done; i++) @(negedge clk);
    check("ignore_done", 32'(done), 32'd1);
    check("ignore_sum", 32'({sum, cout, ovf}), 32'({16'h3333, 1'b0, 1'b0}));
    @(negedge clk);
    @(negedge clk);
    check("ignore_no_rerun", 32'({busy, done}), 32'd0);

    // Back-to-back: start held through DONE.
    start = 1'b1; a = 16'h1234; b = 16'h4321; cin = 1'b0;
    dcnt = 0; first_done = -10; second_done = -10; second_sum = '0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (done) begin
        dcnt++;
        if (dcnt == 1) first_done = c;
        if (dcnt == 2) begin second_done = c; second_sum = sum; end
      end
      if (c == first_done + 1) begin
        check("b2b_no_idle_busy", 32'(busy), 32'd1);
        start = 1'b0;
      end
    end
    check("b2b_done_count", 32'(dcnt), 32'd2);
    check("b2b_spacing", 32'(second_done - first_done), 32'd5);
    check("b2b_second_sum", 32'(second_sum), 32'h5555);

    // Reset in the middle of RUN.
    start = 1'b1; a = 16'h1111; b = 16'h1111; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("partial_sum_visible", 32'({busy, sum}), 32'({1'b1, 16'h0002}));
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", 32'({busy, done, sum, cout, ovf}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    check("abandoned_no_done", 32'(dcnt), 32'd0);
    do_add(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, "after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 Parameter: NIBBLES, default 4, number of 4-bit operand slices (operand width W = 4*NIBBLES); legal range 2..8.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to add; sampled on rising clk.
REQ-005 a  input  W  operand A; sampled only on an accepted start.
REQ-006 b  input  W  operand B; sampled only on an accepted start.
REQ-007 cin  input  1  carry into nibble 0; sampled only on an accepted start.
REQ-008 busy  output  1  high while an addition is in progress.
REQ-009 done  output  1  one-cycle pulse: sum/cout/ovf valid.
REQ-010 sum  output  W  result A+B+cin, modulo 2^W.
REQ-011 cout  output  1  carry out of bit W-1.
REQ-012 ovf  output  1  two's-complement overflow: carry into bit W-1 XOR carry out of bit W-1.

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-014 Start acceptance SHALL occur in IDLE or DONE when start=1 at a rising edge.
- On acceptance: latch a, b, cin; clear sum, cout, ovf to 0; set nibble index to 0; go to RUN.
REQ-015 In RUN, each cycle the block SHALL add latched nibble k of A and B plus the carry register.
- Use one combinational 4-bit carry-lookahead slice: per-bit g=a&b, p=a^b; carries from g/p.
- At the edge: write sum[4k+3:4k], update the carry register to the slice carry-out, k <= k+1.
REQ-016 When k=NIBBLES-1 is processed, the block SHALL:
- load cout with the slice carry-out;
- load ovf with (carry into bit 3 of that slice) XOR (slice carry-out);
- go to DONE.
REQ-017 Latency: with start accepted at edge E0, done SHALL be high from edge E_NIBBLES to edge E_NIBBLES+1, i.e. exactly one cycle.
REQ-018 busy SHALL be 1 exactly while the state is RUN; it is 0 in IDLE and DONE.
REQ-019 done SHALL be 1 exactly while the state is DONE.
REQ-020 DONE SHALL return to IDLE on the next edge when start=0.
REQ-021 start=1 while in DONE SHALL be accepted; done still pulses for that cycle and the next edge enters RUN.
REQ-022 start while busy=1 SHALL be ignored; latched operands and progress are unaffected.
REQ-023 sum, cout and ovf SHALL hold their values after DONE until the next accepted start.
REQ-024 Partial sum nibbles are visible during RUN; consumers SHALL use sum only when done=1 or in IDLE after done.
REQ-025 a, b and cin changing during RUN SHALL have no effect on the result.

Reset
REQ-026 rst_n=0 SHALL immediately, independent of clk, force:
- state IDLE, nibble index 0, carry register 0;
- sum=0, cout=0, ovf=0, busy=0, done=0.
REQ-027 Reset asserted mid-RUN SHALL abandon the operation; no done pulse is produced for it.
REQ-028 After rst_n rises, the first rising edge with start=1 SHALL be accepted normally.

Verification (NIBBLES=4)
REQ-029 a=16'h000B, b=16'h0002, cin=0, start pulse -> after 4 edges done=1, sum=16'h000D, cout=0, ovf=0; busy high for exactly 4 cycles.
REQ-030 a=16'hFFFF, b=16'hFFFF, cin=1 -> sum=16'hFFFF, cout=1, ovf=0.
REQ-031 Overflow cases:
- a=16'h7FFF, b=16'h0001, cin=0 -> sum=16'h8000, cout=0, ovf=1.
- a=16'h8000, b=16'h8000 -> sum=16'h0000, cout=1, ovf=1.
REQ-032 start=1 with new operands during RUN cycle 2 -> ignored; original result delivered; the new operands are not processed.
REQ-033 Back-to-back operation:
- start held high through DONE with a=16'h1234, b=16'h4321 -> second run accepted with no IDLE cycle.
- done pulses twice, 5 cycles apart; second result sum=16'h5555.
REQ-034 rst_n pulsed low mid-RUN (after 2 edges) -> all outputs 0 asynchronously; no done; next start completes correctly.
